imu_seq: RTL and testbench
==========================

Name: imu_seq

Overview:
- Transaction sequencer sitting directly upstream of the 16-bit SPI master; drives its wrt/cmd and consumes its done/rd_data.
- After reset, waits a power-up delay, then issues four IMU configuration writes.
- Then waits for the IMU data-ready interrupt and reads four byte registers (pitch-rate L/H, Z-accel L/H).
- Presents assembled 16-bit ptch_rt and AZ with a one-cycle vld pulse to the downstream balance/integration logic.

Parameters:
- INIT_DLY, 16'hFFFF, clk cycles to wait after reset before the first configuration write (1..65535).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- INT  input  1  IMU data-ready interrupt, asynchronous; double-flopped internally.
- done  input  1  SPI master transaction-complete flag; sticky, cleared by the master one cycle after wrt.
- rd_data  input  16  SPI master receive word; valid when done rises.
- wrt  output  1  one-cycle pulse starting an SPI transaction.
- cmd  output  16  SPI command word; stable from the wrt cycle until the matching done rise.
- ptch_rt  output  16  signed pitch rate {H,L}.
- AZ  output  16  signed Z acceleration {H,L}.
- vld  output  1  one-cycle pulse; ptch_rt and AZ were updated this cycle.
- init_done  output  1  high once all four configuration writes have completed; stays high until rst.

Behaviour:
- Reset values:
  - wrt=0, cmd=16'h0000, ptch_rt=0, AZ=0, vld=0, init_done=0.
  - State=PWR_WAIT, delay counter=0, index=0, INT sync flops=0, done_q=0.
  - rst mid-transaction aborts the sequence immediately. No further wrt is issued until the delay elapses again. Any done arriving during PWR_WAIT is ignored.
- Done edge detection:
  - done_q <= done each cycle; done_rise = done & ~done_q.
  - Only done_rise completes a transaction, because done remains high from the previous transfer until the master clears it.
- INT synchronization: INT_ff1 -> INT_ff2. Only INT_ff2 is used.
- Configuration table (index 0..3): 16'h0D02, 16'h1053, 16'h1150, 16'h1460.
- Read table (index 0..3):
  - 16'hA2xx → ptch_rt[7:0]
  - 16'hA3xx → ptch_rt[15:8]
  - 16'hACxx → AZ[7:0]
  - 16'hADxx → AZ[15:8]
  - xx = 8'h00.
- Data capture: byte = rd_data[7:0], captured into holding registers on done_rise.
- States:
  - PWR_WAIT: counter increments each cycle. When counter == INIT_DLY-1, go to CFG_WR with index=0.
  - CFG_WR: assert wrt for one cycle, cmd=cfg[index]; go to CFG_DN.
  - CFG_DN: on done_rise:
    - if index==3: index<=0, init_done<=1, go to WAIT_INT.
    - else: index++, go to CFG_WR.
  - WAIT_INT: when INT_ff2==1, go to RD_WR with index=0.
  - RD_WR: wrt for one cycle, cmd=rd[index]; go to RD_DN.
  - RD_DN: on done_rise, store byte in holding register [index]:
    - if index==3: go to PUBLISH.
    - else: index++, go to RD_WR.
  - PUBLISH: load ptch_rt/AZ from the holding registers, vld=1 for exactly this cycle, index<=0, go to WAIT_INT.
- Output update rule: ptch_rt/AZ change only in PUBLISH, so a partial read never disturbs the published outputs.
- Timing:
  - wrt never asserts twice without an intervening done_rise.
  - Minimum spacing between successive wrt pulses is 3 cycles.
- Latency: vld follows the fourth done_rise by exactly 2 clk cycles.
- INT still high in PUBLISH (level not yet cleared by the IMU read): a new read sequence starts from WAIT_INT on the next cycle. This is intended.
- INT pulses during CFG_* or RD_* states are ignored; there is no queuing.
- done_rise while in a *_WR state cannot occur; if it does, it is ignored.
- No timeout on done: the sequencer waits indefinitely.

Test Plan:
- Reset, INIT_DLY=16, done model returning done 20 cycles after each wrt.
  - Exactly 4 wrt pulses, first at cycle 17 after rst deasserts, with cmd = 0D02, 1053, 1150, 1460 in order.
  - init_done rises 1 cycle after the 4th done_rise.
- After init, raise INT; SPI model returns bytes 8'h34, 8'h12, 8'hCD, 8'hAB.
  - cmd sequence A200, A300, AC00, AD00.
  - ptch_rt=16'h1234, AZ=16'hABCD, single-cycle vld 2 cycles after the 4th done_rise.
- Leave done stuck high from the previous transfer, and delay the master's clear by 1 cycle after wrt → no spurious advance; the next wrt waits for a true done_rise.
- Toggle INT during RD_DN; hold outputs from a prior read (16'h1234/16'hABCD).
  - Extra INT ignored; ptch_rt/AZ unchanged until PUBLISH.
  - Values switch atomically to the new ones.
- Assert rst for 1 cycle during the second read transaction:
  - all outputs return to reset values, init_done=0.
  - No wrt for INIT_DLY cycles.
  - Full configuration sequence repeats.
- Hold INT high continuously → back-to-back read sequences; vld pulses once per 4-transaction group, never on consecutive cycles.

Source files
------------

// File: rtl/imu_seq.sv
`default_nettype none
// ============================================================================
// Module      : imu_seq
// Description : Drives a 16-bit SPI master to configure an IMU after power-up,
//               then reads pitch rate and Z acceleration on each data-ready.
// Revision    : 1.0  initial release
// ============================================================================
module imu_seq #(
  parameter logic [15:0] INIT_DLY = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        INT,
  input  logic        done,
  input  logic [15:0] rd_data,
  output logic        wrt,
  output logic [15:0] cmd,
  output logic [15:0] ptch_rt,
  output logic [15:0] AZ,
  output logic        vld,
  output logic        init_done
);

  typedef enum logic [2:0] {
    PWR_WAIT = 3'd0,
    CFG_WR   = 3'd1,
    CFG_DN   = 3'd2,
    WAIT_INT = 3'd3,
    RD_WR    = 3'd4,
    RD_DN    = 3'd5,
    PUBLISH  = 3'd6
  } state_t;

  localparam logic [15:0] c_DLY_LAST = INIT_DLY - 16'd1;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_dly_cnt;
  logic [1:0]      r_idx;
  logic            r_int_ff1;
  logic            r_int_ff2;
  logic            r_done_q;
  logic [3:0][7:0] r_hold;
  logic [15:0]     r_ptch_rt;
  logic [15:0]     r_az;
  logic            r_vld;
  logic            r_init_done;
  logic            w_done_rise;
  logic            w_wrt;
  logic [15:0]     w_cmd;
  logic            w_unused_rd_hi;

  function automatic logic [15:0] cfg_word(input logic [1:0] idx);
    case (idx)
      2'd0:    cfg_word = 16'h0D02;
      2'd1:    cfg_word = 16'h1053;
      2'd2:    cfg_word = 16'h1150;
      default: cfg_word = 16'h1460;
    endcase
  endfunction

  // Holding register order: pitch L, pitch H, AZ L, AZ H.
  function automatic logic [15:0] rd_word(input logic [1:0] idx);
    case (idx)
      2'd0:    rd_word = 16'hA200;
      2'd1:    rd_word = 16'hA300;
      2'd2:    rd_word = 16'hAC00;
      default: rd_word = 16'hAD00;
    endcase
  endfunction

  // done stays high from the previous transfer, so only its rising edge counts
  assign w_done_rise    = done & ~r_done_q;
  assign w_unused_rd_hi = ^rd_data[15:8];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_ff1 <= 1'b0;
      r_int_ff2 <= 1'b0;
      r_done_q  <= 1'b0;
    end else begin
      r_int_ff1 <= INT;
      r_int_ff2 <= r_int_ff1;
      r_done_q  <= done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= PWR_WAIT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wrt       = 1'b0;
    w_cmd       = 16'h0000;
    case (r_state)
      PWR_WAIT: if (r_dly_cnt == c_DLY_LAST) w_state_nxt = CFG_WR;
      CFG_WR: begin
        w_wrt       = 1'b1;
        w_cmd       = cfg_word(r_idx);
        w_state_nxt = CFG_DN;
      end
      CFG_DN: begin
        w_cmd = cfg_word(r_idx);
        if (w_done_rise) w_state_nxt = (r_idx == 2'd3) ? WAIT_INT : CFG_WR;
      end
      WAIT_INT: if (r_int_ff2) w_state_nxt = RD_WR;
      RD_WR: begin
        w_wrt       = 1'b1;
        w_cmd       = rd_word(r_idx);
        w_state_nxt = RD_DN;
      end
      RD_DN: begin
        w_cmd = rd_word(r_idx);
        if (w_done_rise) w_state_nxt = (r_idx == 2'd3) ? PUBLISH : RD_WR;
      end
      PUBLISH: w_state_nxt = WAIT_INT;
      default: w_state_nxt = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dly_cnt   <= 16'd0;
      r_idx       <= 2'd0;
      r_hold      <= '0;
      r_ptch_rt   <= 16'd0;
      r_az        <= 16'd0;
      r_vld       <= 1'b0;
      r_init_done <= 1'b0;
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        PWR_WAIT: r_dly_cnt <= r_dly_cnt + 16'd1;
        CFG_DN: begin
          if (w_done_rise) begin
            if (r_idx == 2'd3) begin
              r_idx       <= 2'd0;
              r_init_done <= 1'b1;
            end else begin
              r_idx <= r_idx + 2'd1;
            end
          end
        end
        WAIT_INT: if (r_int_ff2) r_idx <= 2'd0;
        RD_DN: begin
          if (w_done_rise) begin
            r_hold[r_idx] <= rd_data[7:0];
            if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
          end
        end
        // Published outputs move only here, so a partial read never leaks out
        PUBLISH: begin
          r_ptch_rt <= {r_hold[1], r_hold[0]};
          r_az      <= {r_hold[3], r_hold[2]};
          r_vld     <= 1'b1;
          r_idx     <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign wrt       = w_wrt;
  assign cmd       = w_cmd;
  assign ptch_rt   = r_ptch_rt;
  assign AZ        = r_az;
  assign vld       = r_vld;
  assign init_done = r_init_done;

endmodule
`default_nettype wire

// File: tb/tb_imu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_imu_seq
// Description : Self-checking bench for imu_seq with an SPI master / IMU model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_imu_seq;

  localparam logic [15:0] DLY = 16'd16;
  localparam int          LAT = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        INT = 1'b0;
  logic        done = 1'b0;
  logic [15:0] rd_data = 16'h0000;
  logic        wrt;
  logic [15:0] cmd;
  logic [15:0] ptch_rt;
  logic [15:0] AZ;
  logic        vld;
  logic        init_done;

  imu_seq #(.INIT_DLY(DLY)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .INT      (INT),
    .done     (done),
    .rd_data  (rd_data),
    .wrt      (wrt),
    .cmd      (cmd),
    .ptch_rt  (ptch_rt),
    .AZ       (AZ),
    .vld      (vld),
    .init_done(init_done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] exp_cmd(input int k);
    logic [15:0] cfg_t [4];
    logic [15:0] rd_t  [4];
    cfg_t = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460};
    rd_t  = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
    if (k < 4) return cfg_t[k];
    return rd_t[(k - 4) % 4];
  endfunction

  // IMU register file addressed by the command's upper byte
  logic [7:0]  imu_reg [256];
  logic [7:0]  got     [256];
  int          clr_dly = 1;
  int          m_tmr = 0;
  int          m_clr = 0;
  logic [15:0] m_cmd = 16'h0000;

  int          nwr = 0;
  bit          outst = 1'b0;
  int          out_idx = 0;
  int          exp_init_cyc = -1;
  int          exp_vld_cyc = -1;
  int          n_vld = 0;
  logic [15:0] pub_p = 16'h0, pub_a = 16'h0, nxt_p = 16'h0, nxt_a = 16'h0;
  bit          prev_vld = 1'b0, prev_wrt = 1'b0, exp_v;

  // SPI master model plus scoreboard, evaluated on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (m_clr > 0) begin
        m_clr--;
        if (m_clr == 0) done = 1'b0;
      end
      if (m_tmr > 0) begin
        m_tmr--;
        if (m_tmr == 0) begin
          done    = 1'b1;
          rd_data = {8'($urandom), imu_reg[m_cmd[15:8]]};
          if (outst && !rst) begin
            outst = 1'b0;
            if (out_idx == 3) exp_init_cyc = cyc + 1;
            if (out_idx >= 4) begin
              got[m_cmd[15:8]] = rd_data[7:0];
              if ((out_idx - 4) % 4 == 3) begin
                exp_vld_cyc = cyc + 2;
                nxt_p = {got[8'hA3], got[8'hA2]};
                nxt_a = {got[8'hAD], got[8'hAC]};
              end
            end
          end
        end
      end
      if (rst) begin
        nwr = 0; outst = 1'b0; exp_init_cyc = -1; exp_vld_cyc = -1;
        pub_p = 16'h0; pub_a = 16'h0; prev_vld = 1'b0; prev_wrt = 1'b0;
      end else begin
        if (cyc == 0) begin
          chk("rst_wrt", wrt, 0);
          chk("rst_cmd", cmd, 0);
          chk("rst_ptch", ptch_rt, 0);
          chk("rst_az", AZ, 0);
          chk("rst_vld", vld, 0);
          chk("rst_init_done", init_done, 0);
        end
        chk("init_done", init_done, (exp_init_cyc >= 0 && cyc >= exp_init_cyc));
        exp_v = (cyc == exp_vld_cyc);
        chk("vld", vld, exp_v);
        if (exp_v) begin
          pub_p = nxt_p; pub_a = nxt_a; n_vld++;
        end
        chk("ptch_rt", ptch_rt, pub_p);
        chk("AZ", AZ, pub_a);
        chk("vld_consecutive", vld & prev_vld, 0);
        chk("wrt_two_cycles", wrt & prev_wrt, 0);
        if (wrt) begin
          chk("wrt_while_busy", outst, 0);
          chk("cmd", cmd, exp_cmd(nwr));
          if (nwr == 0) chk("first_wrt_cycle", cyc + 1, int'(DLY) + 1);
          out_idx = nwr; nwr++; outst = 1'b1;
          m_tmr = LAT; m_clr = clr_dly; m_cmd = cmd;
        end else if (outst) begin
          chk("cmd_stable", cmd, m_cmd);
        end
        prev_vld = vld;
        prev_wrt = wrt;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_nwr(input int target, input int max);
    for (int k = 0; k < max && nwr < target; k++) tick();
    chk("wrt_timeout", nwr >= target, 1);
  endtask

  task automatic wait_vld(input int v0, input int max);
    for (int k = 0; k < max && n_vld <= v0; k++) tick();
    chk("vld_timeout", n_vld > v0, 1);
  endtask

  task automatic wait_init(input int max);
    for (int k = 0; k < max && !(exp_init_cyc >= 0 && cyc > exp_init_cyc); k++) tick();
    chk("init_done_after_cfg", init_done, 1);
    chk("cfg_wrt_count", nwr, 4);
  endtask

  task automatic do_read(input logic [7:0] pl, ph, al, ah);
    int v0, w0;
    imu_reg[8'hA2] = pl; imu_reg[8'hA3] = ph;
    imu_reg[8'hAC] = al; imu_reg[8'hAD] = ah;
    v0 = n_vld; w0 = nwr;
    tick(); INT = 1'b1;
    wait_nwr(w0 + 1, 20);
    INT = 1'b0;
    wait_vld(v0, 400);
    repeat (2) tick();
  endtask

  // INT pulsed while a read is in flight: outputs hold, no extra read queued
  task automatic int_glitch();
    int v0, w0;
    imu_reg[8'hA2] = 8'h11; imu_reg[8'hA3] = 8'h22;
    imu_reg[8'hAC] = 8'h33; imu_reg[8'hAD] = 8'h44;
    v0 = n_vld; w0 = nwr;
    tick(); INT = 1'b1;
    wait_nwr(w0 + 1, 20);
    INT = 1'b0;
    wait_nwr(w0 + 2, 100);
    repeat (3) tick();
    INT = 1'b1;
    repeat (3) tick();
    INT = 1'b0;
    chk("hold_ptch_mid_read", ptch_rt, 16'h1234);
    chk("hold_az_mid_read", AZ, 16'hABCD);
    wait_vld(v0, 400);
    repeat (2) tick();
    chk("glitch_new_ptch", ptch_rt, 16'h2211);
    chk("glitch_new_az", AZ, 16'h4433);
    repeat (60) tick();
    chk("no_extra_read", nwr, w0 + 4);
  endtask

  typedef struct {
    logic [7:0]  pl, ph, al, ah;
    logic [15:0] ep, ea;
  } vec_t;

  vec_t        vt [4];
  logic [7:0]  b0, b1, b2, b3;
  int          v0, w0;

  initial begin
    vt[0] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 16'h1234, 16'hABCD};
    vt[1] = '{8'h00, 8'h80, 8'hFF, 8'h7F, 16'h8000, 16'h7FFF};
    vt[2] = '{8'hFF, 8'hFF, 8'h01, 8'h00, 16'hFFFF, 16'h0001};
    vt[3] = '{8'h5A, 8'hA5, 8'hC3, 8'h3C, 16'hA55A, 16'h3CC3};
    for (int a = 0; a < 256; a++) begin
      imu_reg[a] = 8'h00;
      got[a]     = 8'h00;
    end
    repeat (3) tick();
    rst = 1'b0;
    wait_init(400);

    for (int i = 0; i < 4; i++) begin
      clr_dly = (i == 2) ? 2 : 1;
      do_read(vt[i].pl, vt[i].ph, vt[i].al, vt[i].ah);
      clr_dly = 1;
      chk("tbl_ptch", ptch_rt, vt[i].ep);
      chk("tbl_az", AZ, vt[i].ea);
      if (i == 0) int_glitch();
    end

    for (int i = 0; i < 6; i++) begin
      b0 = 8'($urandom); b1 = 8'($urandom);
      b2 = 8'($urandom); b3 = 8'($urandom);
      do_read(b0, b1, b2, b3);
      chk("rnd_ptch", ptch_rt, {b1, b0});
      chk("rnd_az", AZ, {b3, b2});
    end

    // One-cycle reset in the middle of the second read transfer
    w0 = nwr;
    tick(); INT = 1'b1;
    wait_nwr(w0 + 1, 20);
    INT = 1'b0;
    wait_nwr(w0 + 2, 100);
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_init_done", init_done, 0);
    chk("midrst_ptch", ptch_rt, 0);
    chk("midrst_az", AZ, 0);
    chk("midrst_vld", vld, 0);
    wait_init(400);

    // INT held high: read groups run back to back
    v0 = n_vld;
    tick(); INT = 1'b1;
    for (int k = 0; k < 1500 && n_vld < v0 + 3; k++) tick();
    INT = 1'b0;
    chk("held_int_groups", n_vld >= v0 + 3, 1);
    repeat (300) tick();
    chk("held_int_whole_groups", (nwr - 4) % 4, 0);
    chk("held_int_idle", outst, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got time limit expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "simulation time limit reached");
  end

endmodule
`default_nettype wire
